fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: FIFO word width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  enables arbitration; 0 parks the block in IDLE.
REQ-006 req  input  NUM_REQ  per-requester write request, level, held until granted.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 gnt  output  NUM_REQ  one-hot write acknowledge; the word is accepted in the cycle gnt[i]=1.
REQ-009 drain_req  input  1  single-cycle pulse requesting the FIFO be emptied.
REQ-010 drain_busy  output  1  high while in DRAIN.
REQ-011 drain_done  output  1  single-cycle pulse when a drain completes.
REQ-012 fifo_wren  output  1  FIFO write enable.
REQ-013 fifo_wdata  output  DATA_WIDTH  FIFO write data.
REQ-014 fifo_rden  output  1  FIFO read enable.
REQ-015 fifo_rdata  input  DATA_WIDTH  FIFO registered read data, valid one cycle after fifo_rden.
REQ-016 fifo_full  input  1  FIFO full flag.
REQ-017 fifo_empty  input  1  FIFO empty flag.
REQ-018 rd_valid  output  1  fifo_rden delayed one cycle.
REQ-019 rd_data  output  DATA_WIDTH  fifo_rdata passed through; meaningful only when rd_valid=1.

Function
REQ-020 FSM states IDLE, ARB, DRAIN, DONE; transitions: IDLE->ARB when en; ARB->DRAIN when drain_req, else ARB->IDLE when !en; DRAIN->DONE when fifo_empty; DONE->ARB when en, else DONE->IDLE.
REQ-021 Grants only in ARB, only when !fifo_full and !drain_req that cycle; at most one gnt bit high.
REQ-022 Round-robin: search starts at index last_ptr+1 modulo NUM_REQ; first requester with req=1 is granted.
REQ-023 last_ptr ($clog2(NUM_REQ) bits) loads the granted index on posedge clk; it is unchanged when no grant.
REQ-024 fifo_wren = |gnt; fifo_wdata = data slice of granted requester, 0 when no grant (combinational, same cycle).
REQ-025 In DRAIN, fifo_rden = !fifo_empty; fifo_rden=0 in all other states.
REQ-026 fifo_wren and fifo_rden never both 1 in a cycle.
REQ-027 DRAIN entered with fifo_empty=1: zero reads, DONE the next cycle.
REQ-028 drain_req in IDLE or DONE is ignored; drain_req in DRAIN is ignored.
REQ-029 drain_done=1 exactly in DONE state; drain_busy=1 exactly in DRAIN state.
REQ-030 Requests pending during DRAIN/DONE are serviced on return to ARB; no request is lost or duplicated.

Reset
REQ-031 While rst=1: state=IDLE, last_ptr=NUM_REQ-1 (requester 0 first after reset), rd_valid=0.
REQ-032 Reset values of outputs: gnt=0, fifo_wren=0, fifo_wdata=0, fifo_rden=0, drain_busy=0, drain_done=0, rd_valid=0.
REQ-033 Reset asserted mid-DRAIN aborts immediately with no drain_done pulse.

Structure
REQ-034 Package fifo_arb_pkg holds the state enum typedef and the default NUM_REQ/DATA_WIDTH constants.
REQ-035 Sub-module rr_arbiter: combinational round-robin picker (req, last_ptr in; one-hot gnt and index out).
REQ-036 fifo_wr_arb holds the FSM, last_ptr, rd_valid register and muxes; target 120-400 RTL lines total.

Verification
REQ-037 Reset, en=1, req=4'b1111 held, fifo_full=0 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-038 req=4'b0101, last_ptr=0 -> gnt=0100; next cycle gnt=0001; fifo_wdata equals the granted slice each cycle.
REQ-039 fifo_full=1 with req=4'b1111 -> gnt=0, fifo_wren=0, last_ptr unchanged; fifo_full drops -> next in order granted.
REQ-040 Eight words written, drain_req pulse -> no grant that cycle, DRAIN with eight fifo_rden cycles, eight rd_valid pulses one cycle later, one drain_done, then ARB.
REQ-041 drain_req with fifo_empty=1 -> DRAIN one cycle, zero fifo_rden, drain_done next cycle.
REQ-042 rst pulse during DRAIN -> all outputs 0 asynchronously, no drain_done; after release, first grant goes to requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts just after last_ptr and wraps.
module rr_arbiter #(
  parameter int  NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx
);

  int   pos_s;
  logic hit_s;
  logic found_s;

  // Scan NUM_REQ positions from last_ptr+1; only the first hit raises its grant bit.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    pos_s   = 0;
    hit_s   = 1'b0;
    found_s = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos_s      = (int'(last_ptr) + k) % NUM_REQ;
      hit_s      = req[pos_s] & ~found_s;
      gnt[pos_s] = hit_s;
      idx        = hit_s ? PTR_W'(pos_s) : idx;
      found_s    = found_s | hit_s;
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin FIFO write arbiter with a drain sequencer that empties the FIFO on request.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          drain_req,
  output logic                          drain_busy,
  output logic                          drain_done,
  output logic                          fifo_wren,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          fifo_rden,
  input  logic [DATA_WIDTH-1:0]         fifo_rdata,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t               state_r;
  state_t               state_s;
  logic [PTR_W-1:0]     last_ptr_r;
  logic [PTR_W-1:0]     arb_idx_s;
  logic [NUM_REQ-1:0]   arb_req_s;
  logic [NUM_REQ-1:0]   arb_gnt_s;
  logic                 grant_ok_s;
  logic                 rd_valid_r;

  // Next-state logic; a drain request outranks a simultaneous disable in ARB.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (en) state_s = ARB;
        else    state_s = IDLE;
      end
      ARB: begin
        if (drain_req) state_s = DRAIN;
        else if (!en)  state_s = IDLE;
        else           state_s = ARB;
      end
      DRAIN: begin
        if (fifo_empty) state_s = DONE;
        else            state_s = DRAIN;
      end
      DONE: begin
        if (en) state_s = ARB;
        else    state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Requests are masked rather than the grants, so last_ptr only moves on a real write.
  assign grant_ok_s = (state_r == ARB) && !fifo_full && !drain_req;
  assign arb_req_s  = grant_ok_s ? req : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req      (arb_req_s),
    .last_ptr (last_ptr_r),
    .gnt      (arb_gnt_s),
    .idx      (arb_idx_s)
  );

  // AND-OR write-data mux; yields zero when nothing is granted.
  always_comb begin
    fifo_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      fifo_wdata = fifo_wdata |
                   (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{arb_gnt_s[i]}});
    end
  end

  assign gnt        = arb_gnt_s;
  assign fifo_wren  = |arb_gnt_s;
  assign fifo_rden  = (state_r == DRAIN) && !fifo_empty;
  assign drain_busy = (state_r == DRAIN);
  assign drain_done = (state_r == DONE);
  assign rd_valid   = rd_valid_r;
  assign rd_data    = rd_valid_r ? fifo_rdata : '0;

  // State, round-robin pointer and read-valid pipeline stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      last_ptr_r <= PTR_W'(NUM_REQ - 1);
      rd_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      rd_valid_r <= fifo_rden;
      if (fifo_wren) last_ptr_r <= arb_idx_s;
      else           last_ptr_r <= last_ptr_r;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with a small behavioural FIFO attached to its write/read ports.
module tb_fifo_wr_arb;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        drain_req;
  logic        drain_busy;
  logic        drain_done;
  logic        fifo_wren;
  logic [7:0]  fifo_wdata;
  logic        fifo_rden;
  logic [7:0]  fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        force_full;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];
  int         wp  = 0;
  int         rp  = 0;
  int         cnt = 0;
  logic [7:0] exp_words [8];
  logic [3:0] exp_gnt [4];
  logic [7:0] exp_dat [4];

  fifo_wr_arb #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .drain_req  (drain_req),
    .drain_busy (drain_busy),
    .drain_done (drain_done),
    .fifo_wren  (fifo_wren),
    .fifo_wdata (fifo_wdata),
    .fifo_rden  (fifo_rden),
    .fifo_rdata (fifo_rdata),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural 16-deep FIFO with registered read data.
  always @(posedge clk) begin
    if (fifo_wren) begin
      mem[wp[3:0]] <= fifo_wdata;
      wp <= wp + 1;
    end
    if (fifo_rden) begin
      fifo_rdata <= mem[rp[3:0]];
      rp <= rp + 1;
    end
    cnt <= cnt + (fifo_wren ? 1 : 0) - (fifo_rden ? 1 : 0);
  end

  assign fifo_empty = (cnt == 0);
  assign fifo_full  = force_full | (cnt == 16);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; en = 1'b0; req = 4'b0000; drain_req = 1'b0;
    force_full = 1'b0; fifo_rdata = 8'h00;
    req_data = 32'h44332211;
    exp_words[0] = 8'h11; exp_words[1] = 8'h22; exp_words[2] = 8'h33; exp_words[3] = 8'h44;
    exp_words[4] = 8'h11; exp_words[5] = 8'h33; exp_words[6] = 8'h11; exp_words[7] = 8'h22;
    exp_gnt[0] = 4'b0010; exp_gnt[1] = 4'b0100; exp_gnt[2] = 4'b1000; exp_gnt[3] = 4'b0001;
    exp_dat[0] = 8'h22;   exp_dat[1] = 8'h33;   exp_dat[2] = 8'h44;   exp_dat[3] = 8'h11;

    #3;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_wren", 32'(fifo_wren), 32'h0);
    check("rst_wdata", 32'(fifo_wdata), 32'h0);
    check("rst_rden", 32'(fifo_rden), 32'h0);
    check("rst_busy", 32'(drain_busy), 32'h0);
    check("rst_done", 32'(drain_done), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);

    tick(); rst = 1'b0;
    tick(); en = 1'b1; #1;
    check("idle_no_gnt", 32'(gnt), 32'h0);
    tick();

    // Drain of an empty FIFO: one DRAIN cycle without reads, then DONE.
    drain_req = 1'b1; #1;
    check("edrain_req_busy", 32'(drain_busy), 32'h0);
    tick(); drain_req = 1'b0; #1;
    check("edrain_busy", 32'(drain_busy), 32'h1);
    check("edrain_rden", 32'(fifo_rden), 32'h0);
    check("edrain_done0", 32'(drain_done), 32'h0);
    tick(); #1;
    check("edrain_done", 32'(drain_done), 32'h1);
    check("edrain_busy0", 32'(drain_busy), 32'h0);
    check("edrain_rden0", 32'(fifo_rden), 32'h0);
    tick();

    // All four requesting: rotation starts at requester 0.
    req = 4'b1111; #1;
    check("rr_gnt0", 32'(gnt), 32'h1);
    check("rr_wdata0", 32'(fifo_wdata), 32'h11);
    check("rr_wren0", 32'(fifo_wren), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      check("rr_gnt", 32'(gnt), 32'(exp_gnt[i]));
      check("rr_wdata", 32'(fifo_wdata), 32'(exp_dat[i]));
    end

    // Sparse requests 0101 with last_ptr = 0.
    req = 4'b0101;
    tick(); #1;
    check("sp_gnt_a", 32'(gnt), 32'h4);
    check("sp_wdata_a", 32'(fifo_wdata), 32'h33);
    tick(); #1;
    check("sp_gnt_b", 32'(gnt), 32'h1);
    check("sp_wdata_b", 32'(fifo_wdata), 32'h11);

    // Full FIFO holds off grants and the pointer.
    tick(); req = 4'b1111; force_full = 1'b1; #1;
    check("full_gnt", 32'(gnt), 32'h0);
    check("full_wren", 32'(fifo_wren), 32'h0);
    check("full_wdata", 32'(fifo_wdata), 32'h0);
    tick(); #1;
    check("full_gnt2", 32'(gnt), 32'h0);
    force_full = 1'b0; #1;
    check("unfull_gnt", 32'(gnt), 32'h2);
    check("unfull_wdata", 32'(fifo_wdata), 32'h22);

    // Eight words stored; drain them while requester 2 waits.
    tick(); req = 4'b0100; drain_req = 1'b1; #1;
    check("dreq_gnt", 32'(gnt), 32'h0);
    check("dreq_wren", 32'(fifo_wren), 32'h0);
    tick(); drain_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("drain_rden", 32'(fifo_rden), 32'h1);
      check("drain_busy", 32'(drain_busy), 32'h1);
      check("drain_gnt", 32'(gnt), 32'h0);
      check("drain_done", 32'(drain_done), 32'h0);
      check("drain_rd_valid", 32'(rd_valid), (k > 0) ? 32'h1 : 32'h0);
      if (k > 0) check("drain_rd_data", 32'(rd_data), 32'(exp_words[k-1]));
      tick();
    end
    #1;
    check("dtail_rden", 32'(fifo_rden), 32'h0);
    check("dtail_busy", 32'(drain_busy), 32'h1);
    check("dtail_rd_valid", 32'(rd_valid), 32'h1);
    check("dtail_rd_data", 32'(rd_data), 32'h22);
    check("dtail_done", 32'(drain_done), 32'h0);
    tick(); #1;
    check("dfin_done", 32'(drain_done), 32'h1);
    check("dfin_busy", 32'(drain_busy), 32'h0);
    check("dfin_rd_valid", 32'(rd_valid), 32'h0);
    check("dfin_gnt", 32'(gnt), 32'h0);
    tick(); #1;
    check("pend_gnt", 32'(gnt), 32'h4);
    check("pend_wdata", 32'(fifo_wdata), 32'h33);

    // Reset in the middle of a drain.
    tick(); req = 4'b0000; drain_req = 1'b1;
    tick(); drain_req = 1'b0; #1;
    check("mid_rden", 32'(fifo_rden), 32'h1);
    rst = 1'b1; #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_wren", 32'(fifo_wren), 32'h0);
    check("arst_wdata", 32'(fifo_wdata), 32'h0);
    check("arst_rden", 32'(fifo_rden), 32'h0);
    check("arst_busy", 32'(drain_busy), 32'h0);
    check("arst_done", 32'(drain_done), 32'h0);
    check("arst_rd_valid", 32'(rd_valid), 32'h0);
    tick(); #1;
    check("arst_done_hold", 32'(drain_done), 32'h0);
    rst = 1'b0; req = 4'b1111; #1;
    check("post_idle_gnt", 32'(gnt), 32'h0);
    tick(); #1;
    check("post_gnt", 32'(gnt), 32'h1);
    check("post_wdata", 32'(fifo_wdata), 32'h11);

    // Disable returns to IDLE, where nothing is granted.
    en = 1'b0;
    tick(); #1;
    check("dis_gnt", 32'(gnt), 32'h0);
    check("dis_wren", 32'(fifo_wren), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
